// File: rtl/clock_pkg.sv
// Shared BCD types and digit limits for the minutes:seconds timekeeping path.
package clock_pkg;
    typedef logic [3:0] bcd_t;

    localparam bcd_t TENS_MAX = 4'd5;
    localparam bcd_t ONES_MAX = 4'd9;
endpackage

// File: rtl/mmss_counter_bcd60.sv
// Two-digit BCD mod-60 counter advancing by 0, 1 or 2 per cycle.
module bcd60_counter
    import clock_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic [1:0] step,
    output bcd_t       tens,
    output bcd_t       ones,
    output logic       carry
);
    function automatic logic [7:0] inc60(input bcd_t t, input bcd_t o);
        if (o != ONES_MAX)      return {t, o + 4'd1};
        else if (t != TENS_MAX) return {t + 4'd1, 4'd0};
        else                    return 8'd0;
    endfunction

    logic [7:0] one_up, two_up, nxt;

    assign one_up = inc60(tens, ones);
    assign two_up = inc60(one_up[7:4], one_up[3:0]);

    always_comb begin
        nxt = {tens, ones};
        case (step)
            2'd0:    nxt = {tens, ones};
            2'd1:    nxt = one_up;
            default: nxt = two_up;
        endcase
    end

    // Carry marks the first unit of the step leaving 59; the caller orders tick before button.
    assign carry = (step != 2'd0) && (tens == TENS_MAX) && (ones == ONES_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens <= '0;
            ones <= '0;
        end else if (clear) begin
            tens <= '0;
            ones <= '0;
        end else begin
            tens <= nxt[7:4];
            ones <= nxt[3:0];
        end
    end
endmodule

// File: rtl/mmss_counter.sv
// Minutes:seconds timekeeper: prescaler to 1 Hz tick, BCD digits, synchronized minute-advance button.
module mmss_counter
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    input  logic i_clear,
    input  logic i_btn_min,
    output bcd_t o_sec_ones,
    output bcd_t o_sec_tens,
    output bcd_t o_min_ones,
    output bcd_t o_min_tens,
    output logic o_tick,
    output logic o_wrap
);
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] pre;
    logic          at_end, tick_now;
    logic          sync1, sync2, btn_prev, btn_pulse;
    logic          sec_carry, min_carry;
    logic [1:0]    sec_step, min_step;

    assign at_end   = (pre == CW'(TICK_DIV - 1));
    assign tick_now = i_run & at_end & ~i_clear;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)     pre <= '0;
        else if (i_clear) pre <= '0;
        else if (i_run)   pre <= at_end ? '0 : pre + 1'b1;
    end

    // Synchronizer and edge flops ignore clear so a held button is not re-detected afterwards.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            btn_prev <= 1'b0;
        end else begin
            sync1    <= i_btn_min;
            sync2    <= sync1;
            btn_prev <= sync2;
        end
    end

    assign btn_pulse = sync2 & ~btn_prev & ~i_clear;
    assign sec_step  = {1'b0, tick_now};
    assign min_step  = {1'b0, sec_carry} + {1'b0, btn_pulse};

    bcd60_counter u_sec (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clear (i_clear),
        .step  (sec_step),
        .tens  (o_sec_tens),
        .ones  (o_sec_ones),
        .carry (sec_carry)
    );

    bcd60_counter u_min (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clear (i_clear),
        .step  (min_step),
        .tens  (o_min_tens),
        .ones  (o_min_ones),
        .carry (min_carry)
    );

    // Wrap only when the tick carry itself crosses 59 -> 00; a button-only step never wraps.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_tick <= 1'b0;
            o_wrap <= 1'b0;
        end else begin
            o_tick <= tick_now;
            o_wrap <= sec_carry & min_carry;
        end
    end
endmodule

// File: tb/tb_mmss_counter.sv
// Scoreboarded random/directed bench for mmss_counter against a total-seconds reference model.
module tb_mmss_counter;
    localparam int D = 4;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_run = 1'b0;
    logic       i_clear = 1'b0;
    logic       i_btn_min = 1'b0;
    logic [3:0] o_sec_ones, o_sec_tens, o_min_ones, o_min_tens;
    logic       o_tick, o_wrap;

    mmss_counter #(.TICK_DIV(D)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_run      (i_run),
        .i_clear    (i_clear),
        .i_btn_min  (i_btn_min),
        .o_sec_ones (o_sec_ones),
        .o_sec_tens (o_sec_tens),
        .o_min_ones (o_min_ones),
        .o_min_tens (o_min_tens),
        .o_tick     (o_tick),
        .o_wrap     (o_wrap)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [3:0] mt, mo, st, so;
        logic       tick, wrap;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: total seconds of the day-hour, prescaler phase, and sampled button history.
    int   m_t = 0, m_pre = 0;
    logic b1 = 0, b2 = 0, b3 = 0;
    int   n_wraps = 0;

    function automatic obs_t pack_exp(int t, logic tk, logic wr);
        obs_t r;
        r.mt = 4'((t / 60) / 10);
        r.mo = 4'((t / 60) % 10);
        r.st = 4'((t % 60) / 10);
        r.so = 4'((t % 60) % 10);
        r.tick = tk;
        r.wrap = wr;
        return r;
    endfunction

    task automatic drive_push(input logic run, input logic clr, input logic btn);
        logic pulse, tk, wr;
        int m, s, carry;
        i_run = run; i_clear = clr; i_btn_min = btn;
        pulse = b2 & ~b3;
        tk = 0; wr = 0;
        if (clr) begin
            m_pre = 0; m_t = 0;
        end else begin
            tk = run && (m_pre == D - 1);
            if (run) m_pre = (m_pre + 1) % D;
            m = m_t / 60; s = m_t % 60; carry = 0;
            if (tk) begin
                s = s + 1;
                if (s == 60) begin s = 0; carry = 1; end
            end
            wr = (carry == 1) && (m == 59);
            m = (m + carry + (pulse ? 1 : 0)) % 60;
            m_t = m * 60 + s;
        end
        if (wr) n_wraps++;
        b3 = b2; b2 = b1; b1 = btn;
        exp_q.push_back(pack_exp(m_t, tk, wr));
    endtask

    task automatic cyc(input logic run, input logic clr, input logic btn);
        @(negedge i_clk);
        drive_push(run, clr, btn);
    endtask

    task automatic press_to(input int target);
        int n;
        n = (target - m_t / 60 + 60) % 60;
        for (int k = 0; k < n; k++) begin
            cyc(0, 0, 1);
            cyc(0, 0, 0);
        end
        repeat (3) cyc(0, 0, 0);
    endtask

    task automatic run_until(input int t, input int p);
        for (int k = 0; k < 4000; k++) begin
            if (m_t == t && m_pre == p) break;
            cyc(1, 0, 0);
        end
    endtask

    task automatic aligned_press();
        repeat (3) cyc(1, 0, 1);
        repeat (3) cyc(1, 0, 0);
    endtask

    obs_t mon_e, mon_a;
    always @(posedge i_clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {o_min_tens, o_min_ones, o_sec_tens, o_sec_ones, o_tick, o_wrap};
            n_checks++;
            if (mon_a !== mon_e) begin
                n_errors++;
                $display("FAIL outputs @%0t got %0h%0h:%0h%0h tick=%0b wrap=%0b want %0h%0h:%0h%0h tick=%0b wrap=%0b",
                         $time, mon_a.mt, mon_a.mo, mon_a.st, mon_a.so, mon_a.tick, mon_a.wrap,
                         mon_e.mt, mon_e.mo, mon_e.st, mon_e.so, mon_e.tick, mon_e.wrap);
            end
        end
    end

    task automatic check_zero(input string name);
        obs_t a;
        a = {o_min_tens, o_min_ones, o_sec_tens, o_sec_ones, o_tick, o_wrap};
        n_checks++;
        if (a !== '0) begin
            n_errors++;
            $display("FAIL %s got %0h want 0", name, a);
        end
    endtask

    initial begin
        logic btn_r;
        btn_r = 0;
        repeat (3) @(negedge i_clk);
        #2 check_zero("reset_state");
        i_rst_n = 1'b1;

        // Plain counting, then through 00:59 -> 01:00
        repeat (12) cyc(1, 0, 0);
        repeat (240) cyc(1, 0, 0);

        // Button+tick coincidence at 58:59 and 59:59
        press_to(58);
        run_until(58 * 60 + 59, D - 3);
        aligned_press();
        press_to(59);
        run_until(59 * 60 + 59, D - 3);
        aligned_press();

        // Tick-only wrap at 59:59
        press_to(59);
        run_until(59 * 60 + 59, D - 1);
        repeat (3) cyc(1, 0, 0);

        // Hold with prescaler at 2
        run_until(m_t + 1, 2);
        repeat (20) cyc(0, 0, 0);
        repeat (4) cyc(1, 0, 0);

        // Clear in the cycle a tick would fire at 12:34
        press_to(12);
        run_until(12 * 60 + 34, D - 1);
        cyc(1, 1, 0);
        repeat (7) cyc(1, 0, 0);

        // Async reset mid-count
        @(negedge i_clk);
        #1 i_rst_n = 1'b0;
        #1 check_zero("async_reset");
        m_t = 0; m_pre = 0; b1 = 0; b2 = 0; b3 = 0;
        #1 i_rst_n = 1'b1;
        drive_push(1, 0, 0);
        repeat (9) cyc(1, 0, 0);

        // Random phase
        for (int k = 0; k < 5000; k++) begin
            if ($urandom_range(0, 7) == 0) btn_r = ~btn_r;
            cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 299) == 0), btn_r);
        end

        @(negedge i_clk);
        @(negedge i_clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        n_checks++;
        if (n_wraps < 2) begin
            n_errors++;
            $display("FAIL wrap_coverage got %0d want >=2", n_wraps);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
